// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: opcodes, instruction field positions,
// hazard FSM state type and an operand-use helper.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_LW    = 6'h23;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   typedef enum logic {HZ_RUN = 1'b0, HZ_FLUSH = 1'b1} hz_state_t;

   // Instructions that read rt as a source operand (loads write it instead).
   function automatic logic op_uses_rt(input logic [5:0] op);
      logic r;
      case (op)
         OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: r = 1'b1;
         default:                         r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on inc, holding at all-ones.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= {W{1'b0}};
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and redirect flush control for the 5-stage MIPS32 pipeline.
// Optional performance counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      id_ir,
   input  logic             idex_mem_read,
   input  logic [4:0]       idex_write_addr,
   input  logic             ex_redirect,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             hazard_detected,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hz_state_t   state;
   logic [3:0]  fl_left;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        load_use;
   logic        unused_ir_bits;

   assign rs             = id_ir[RS_MSB:RS_LSB];
   assign rt             = id_ir[RT_MSB:RT_LSB];
   assign unused_ir_bits = ^id_ir[15:0];

   // $zero is never a real dependency, so a zero destination cannot stall.
   assign load_use = idex_mem_read && (idex_write_addr != 5'd0) &&
                     ((idex_write_addr == rs) ||
                      (op_uses_rt(id_ir[31:26]) && (idex_write_addr == rt)));

   // Flush sequencer: a redirect in EX opens a window of FLUSH_CYCLES bubbles.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= HZ_RUN;
         fl_left <= 4'd0;
      end else begin
         case (state)
            HZ_RUN: begin
               if (ex_redirect && (FLUSH_CYCLES > 1)) begin
                  state   <= HZ_FLUSH;
                  fl_left <= 4'(FLUSH_CYCLES - 1);
               end else begin
                  state   <= HZ_RUN;
                  fl_left <= 4'd0;
               end
            end
            HZ_FLUSH: begin
               if (ex_redirect) begin
                  state   <= HZ_FLUSH;
                  fl_left <= 4'(FLUSH_CYCLES - 1);
               end else if (fl_left <= 4'd1) begin
                  state   <= HZ_RUN;
                  fl_left <= 4'd0;
               end else begin
                  state   <= HZ_FLUSH;
                  fl_left <= fl_left - 4'd1;
               end
            end
            default: begin
               state   <= HZ_RUN;
               fl_left <= 4'd0;
            end
         endcase
      end
   end

   // Control outputs respond in the same cycle so ID/EX sees them at this edge.
   always_comb begin
      hazard_detected = 1'b0;
      ifid_flush      = 1'b0;
      pc_write        = 1'b1;
      ifid_write      = 1'b1;
      if (!reset) begin
         hazard_detected = 1'b1;
         ifid_flush      = 1'b1;
         pc_write        = 1'b0;
         ifid_write      = 1'b0;
      end else if ((state == HZ_FLUSH) || ex_redirect) begin
         hazard_detected = 1'b1;
         ifid_flush      = 1'b1;
      end else if (load_use) begin
         hazard_detected = 1'b1;
         pc_write        = 1'b0;
         ifid_write      = 1'b0;
      end else begin
         hazard_detected = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic stall_inc;
   logic flush_inc;

   assign stall_inc = (state == HZ_RUN) && load_use && !ex_redirect;
   assign flush_inc = (state == HZ_FLUSH) || ex_redirect;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (flush_inc),
      .count (flush_cnt)
   );
`else
   assign stall_cnt = {CNT_W{1'b0}};
   assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Producer side of the ID/EX flush interface: generates `hazard_detected`, the bubble/flush request consumed by the ID/EX pipeline register.
- Also drives the PC and IF/ID hold and flush controls.
- Detects load-use data hazards combinationally in ID.
- Runs a small FSM that sequences multi-cycle control-flow flushes after a branch or jump is resolved in EX.
- Sits between the ID-stage decode, the ID/EX register and the fetch logic of the 5-stage MIPS32 pipeline.

Parameters:
- FLUSH_CYCLES, 1: number of consecutive cycles bubbles are injected after a redirect. Legal range 1..15.
- CNT_W, 16: width of the performance counters.

Ports:
- clock  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_ir  input  32  instruction currently held in IF/ID.
- idex_mem_read  input  1  instruction in ID/EX is a load.
- idex_write_addr  input  5  destination register of the instruction in ID/EX.
- ex_redirect  input  1  branch taken or jump resolved in EX this cycle.
- pc_write  output  1  PC update enable (0 = hold PC).
- ifid_write  output  1  IF/ID load enable (0 = hold IF/ID).
- ifid_flush  output  1  IF/ID loads a NOP at the next edge.
- hazard_detected  output  1  ID/EX loads a bubble (control fields zeroed) at the next edge.
- stall_cnt  output  CNT_W  number of load-use stall cycles (only with the optional feature).
- flush_cnt  output  CNT_W  number of flush cycles (only with the optional feature).

Behaviour:
- Field decode: rs = id_ir[25:21]; rt = id_ir[20:16]; op = id_ir[31:26].
- uses_rt = 1 when op is 0x00 (R-type), 0x04 (beq), 0x05 (bne) or 0x2B (sw).
- load_use = idex_mem_read AND idex_write_addr != 0 AND (idex_write_addr == rs OR (uses_rt AND idex_write_addr == rt)).
- FSM states: RUN and FLUSH. A 4-bit register `fl_left` holds the remaining flush cycles.
- RUN, priority 1 — ex_redirect=1:
  - Outputs: hazard_detected=1, ifid_flush=1, pc_write=1, ifid_write=1 (the PC takes the redirect target).
  - If FLUSH_CYCLES>1: go to FLUSH with fl_left = FLUSH_CYCLES-1. Otherwise stay in RUN.
  - A simultaneous load_use is ignored, since the ID instruction is on the wrong path.
- RUN, priority 2 — load_use=1:
  - Outputs: hazard_detected=1, pc_write=0, ifid_write=0, ifid_flush=0.
  - Exactly one bubble is inserted. The next cycle re-evaluates, and normally idex_mem_read=0 then, so no second stall occurs.
- RUN, otherwise: hazard_detected=0, ifid_flush=0, pc_write=1, ifid_write=1.
- FLUSH: hazard_detected=1, ifid_flush=1, pc_write=1, ifid_write=1; load_use is ignored.
  - Each cycle fl_left decrements; when fl_left==1 at a clock edge, the FSM returns to RUN.
  - A new ex_redirect while in FLUSH reloads fl_left = FLUSH_CYCLES-1. If FLUSH_CYCLES==1 it is handled by the RUN rule above.
- Outputs are combinational from state and inputs, so the response takes effect at the same edge as the hazard (zero-cycle latency into ID/EX).
- While reset is low, independent of clock:
  - state=RUN, fl_left=0, counters=0.
  - Outputs forced to hazard_detected=1, ifid_flush=1, pc_write=0, ifid_write=0.
- Release of reset takes effect at the next edge in RUN. Asserting reset during FLUSH aborts the flush immediately.
- idex_write_addr==0 never triggers a stall, since $zero is never a real dependency.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each edge where RUN and load_use and !ex_redirect.
  - flush_cnt increments on each edge where hazard_detected=1 due to a redirect or the FLUSH state.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the counter registers are not instantiated and stall_cnt/flush_cnt are tied to 0.

Decomposition:
- Shared package `mips_pkg`:
  - opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW.
  - field-position constants RS_MSB/LSB, RT_MSB/LSB.
  - state typedef hz_state_t {HZ_RUN, HZ_FLUSH}.
- One sub-module: `sat_counter` (parameter W; inc, clock, reset), instantiated twice under the macro.

Test Plan:
- Load-use on rs: idex_mem_read=1, idex_write_addr=8, id_ir=add $9,$8,$10 (0x010A4820).
  - Expect: one cycle of hazard_detected=1, pc_write=0, ifid_write=0.
  - Next cycle, with idex_mem_read=0: all controls return to normal.
- Non-stall cases:
  - Same load with id_ir=lw $9,0($10) (rt is a destination): no stall.
  - idex_write_addr=0: no stall.
- Load-use on rt for sw: idex_write_addr=5, id_ir=sw $5,4($6) (0xACC50004) -> stall asserted for one cycle.
- Redirect with FLUSH_CYCLES=3, ex_redirect pulsed for one cycle:
  - Expect: hazard_detected=1 and ifid_flush=1 for exactly 3 cycles, pc_write=1 throughout, then RUN.
  - With HAZARD_PERF_CNT_EN defined: flush_cnt=3.
- Simultaneous ex_redirect=1 and load_use=1:
  - Expect: flush behaviour, pc_write=1.
  - stall_cnt unchanged.
- Reset mid-FLUSH: drop reset during the 2nd flush cycle.
  - Expect: outputs forced to reset values immediately, counters 0.
  - After release: RUN, with no residual flush cycles.
